// File: rtl/heap_pkg.sv
// Shared heap arbiter types: action codes, FSM state, action check.
// Imported by heap_rr_pick and heap_arbiter.
package heap_pkg;

  localparam logic [7:0] HEAP_ACTION_SIZE    = 8'd4;
  localparam logic [7:0] HEAP_ACTION_GREATER = 8'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } heap_state_e;

  function automatic logic heap_action_ok(
    input logic [7:0] act
  );
    return (act == HEAP_ACTION_SIZE) ||
           (act == HEAP_ACTION_GREATER);
  endfunction

endpackage

// File: rtl/heap_rr_pick.sv
// Round-robin pick: first set req at or after ptr, wrapping.
// Ports: req_i, ptr_i -> grant_o (one-hot), idx_o, valid_o.
module heap_rr_pick
  import heap_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    logic [PW:0]   s;
    logic [PW-1:0] j;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    s       = '0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr_i} + (PW+1)'(k);
      if (s >= (PW+1)'(N)) begin
        s = s - (PW+1)'(N);
      end
      j = s[PW-1:0];
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing one heap memory among requesters.
// Ports: clock, reset (async low), req/req_* in, ack/resp_* out,
// mem_* command bus, mem_out/mem_error in, stats_grants out.
// Macro HEAP_ARBITER_STATS_EN builds saturating grant counters.
module heap_arbiter
  import heap_pkg::*;
#(
  parameter int REQUESTERS   = 4,
  parameter int ADDRESS_BITS = 2,
  parameter int INDEX_BITS   = 1,
  parameter int DATA_BITS    = 12,
  parameter int LATENCY      = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [REQUESTERS-1:0]            req,
  input  logic [8*REQUESTERS-1:0]          req_action,
  input  logic [ADDRESS_BITS*REQUESTERS-1:0] req_array,
  input  logic [INDEX_BITS*REQUESTERS-1:0] req_index,
  input  logic [DATA_BITS*REQUESTERS-1:0]  req_in,
  output logic [REQUESTERS-1:0]            ack,
  output logic [DATA_BITS-1:0]             resp_out,
  output logic                             resp_error,
  output logic                             mem_clock,
  output logic [7:0]                       mem_action,
  output logic [ADDRESS_BITS-1:0]          mem_array,
  output logic [INDEX_BITS-1:0]            mem_index,
  output logic [DATA_BITS-1:0]             mem_in,
  input  logic [DATA_BITS-1:0]             mem_out,
  input  logic [31:0]                      mem_error,
  output logic [16*REQUESTERS-1:0]         stats_grants
);

  localparam int RW = REQUESTERS;
  localparam int AB = ADDRESS_BITS;
  localparam int IB = INDEX_BITS;
  localparam int DB = DATA_BITS;
  localparam int PW = (RW > 1) ? $clog2(RW) : 1;

  heap_state_e   state_q;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] win_q, ack_q;
  logic [3:0]    cnt_q;

  logic [7:0]    op_act_q, sel_act;
  logic [AB-1:0] op_arr_q, sel_arr;
  logic [IB-1:0] op_idx_q, sel_idx;
  logic [DB-1:0] op_in_q,  sel_in;

  logic          mclk_q;
  logic [7:0]    mact_q;
  logic [AB-1:0] marr_q;
  logic [IB-1:0] midx_q;
  logic [DB-1:0] min_q;
  logic [DB-1:0] rout_q;
  logic          rerr_q;

  logic [RW-1:0] grant;
  logic [PW-1:0] pick_idx;
  logic          pick_vld;

  heap_rr_pick #(
    .N  (RW),
    .PW (PW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  assign ptr_d = (pick_idx == PW'(RW-1)) ?
                 '0 : pick_idx + PW'(1);

  always_comb begin
    sel_act = '0;
    sel_arr = '0;
    sel_idx = '0;
    sel_in  = '0;
    for (int k = 0; k < RW; k++) begin
      if (grant[k]) begin
        sel_act = req_action[8*k +: 8];
        sel_arr = req_array[AB*k +: AB];
        sel_idx = req_index[IB*k +: IB];
        sel_in  = req_in[DB*k +: DB];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      ack_q    <= '0;
      cnt_q    <= '0;
      op_act_q <= '0;
      op_arr_q <= '0;
      op_idx_q <= '0;
      op_in_q  <= '0;
      mclk_q   <= 1'b0;
      mact_q   <= '0;
      marr_q   <= '0;
      midx_q   <= '0;
      min_q    <= '0;
      rout_q   <= '0;
      rerr_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            win_q    <= grant;
            ptr_q    <= ptr_d;
            op_act_q <= sel_act;
            op_arr_q <= sel_arr;
            op_idx_q <= sel_idx;
            op_in_q  <= sel_in;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mact_q <= op_act_q;
          marr_q <= op_arr_q;
          midx_q <= op_idx_q;
          min_q  <= op_in_q;
          // unsupported codes never reach the heap
          if (heap_action_ok(op_act_q)) begin
            mclk_q <= ~mclk_q;
          end
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          ack_q <= win_q;
          if (heap_action_ok(op_act_q)) begin
            rout_q <= mem_out;
            rerr_q <= |mem_error;
          end else begin
            rout_q <= '0;
            rerr_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign resp_out   = rout_q;
  assign resp_error = rerr_q;
  assign mem_clock  = mclk_q;
  assign mem_action = mact_q;
  assign mem_array  = marr_q;
  assign mem_index  = midx_q;
  assign mem_in     = min_q;

`ifdef HEAP_ARBITER_STATS_EN
  logic [15:0] st_q [RW];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < RW; k++) begin
        st_q[k] <= '0;
      end
    end else if (state_q == ST_IDLE && pick_vld) begin
      for (int k = 0; k < RW; k++) begin
        if (grant[k] && st_q[k] != 16'hFFFF) begin
          st_q[k] <= st_q[k] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stats_grants = '0;
    for (int k = 0; k < RW; k++) begin
      stats_grants[16*k +: 16] = st_q[k];
    end
  end
`else
  assign stats_grants = '0;
`endif

endmodule

// File: tb/tb_heap_arbiter.sv
// Randomized self-checking bench for heap_arbiter against a
// transaction-level model; includes directed scenarios.
module tb_heap_arbiter;

  localparam int N   = 4;
  localparam int AB  = 2;
  localparam int IB  = 1;
  localparam int DB  = 12;
  localparam int LAT = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [8*N-1:0]  req_action = '0;
  logic [AB*N-1:0] req_array = '0;
  logic [IB*N-1:0] req_index = '0;
  logic [DB*N-1:0] req_in = '0;
  logic [N-1:0]    ack;
  logic [DB-1:0]   resp_out;
  logic            resp_error;
  logic            mem_clock;
  logic [7:0]      mem_action;
  logic [AB-1:0]   mem_array;
  logic [IB-1:0]   mem_index;
  logic [DB-1:0]   mem_in;
  logic [DB-1:0]   mem_out = '0;
  logic [31:0]     mem_error = '0;
  logic [16*N-1:0] stats_grants;

  heap_arbiter #(
    .REQUESTERS   (N),
    .ADDRESS_BITS (AB),
    .INDEX_BITS   (IB),
    .DATA_BITS    (DB),
    .LATENCY      (LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_action   (req_action),
    .req_array    (req_array),
    .req_index    (req_index),
    .req_in       (req_in),
    .ack          (ack),
    .resp_out     (resp_out),
    .resp_error   (resp_error),
    .mem_clock    (mem_clock),
    .mem_action   (mem_action),
    .mem_array    (mem_array),
    .mem_index    (mem_index),
    .mem_in       (mem_in),
    .mem_out      (mem_out),
    .mem_error    (mem_error),
    .stats_grants (stats_grants)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // toy heap: result depends only on the operands it saw
  function automatic logic [DB-1:0] heap_f(
    input logic [AB-1:0] arr,
    input logic [IB-1:0] idx,
    input logic [DB-1:0] din);
    logic [DB-1:0] r;
    r = din + DB'(arr) + DB'(idx);
    return r;
  endfunction

  function automatic logic [31:0] heap_e(
    input logic [DB-1:0] din);
    return (din[3:0] == 4'd5) ? 32'd5 : 32'd0;
  endfunction

  function automatic bit act_ok(input logic [7:0] a);
    return (a == 8'd4) || (a == 8'd9);
  endfunction

  // transaction-level model
  bit            m_busy;
  int            m_d, m_w, m_ptr;
  logic [7:0]    m_act;
  logic [AB-1:0] m_arr;
  logic [IB-1:0] m_idx;
  logic [DB-1:0] m_in;
  logic [N-1:0]  e_ack;
  logic [DB-1:0] e_out;
  logic          e_err, e_mc;
  logic [7:0]    e_ma;
  logic [AB-1:0] e_marr;
  logic [IB-1:0] e_midx;
  logic [DB-1:0] e_min;
  int            e_st [N];
  logic          last_mc = 1'b0;

  task automatic model_reset();
    m_busy = 0; m_d = 0; m_w = 0; m_ptr = 0;
    m_act = '0; m_arr = '0; m_idx = '0; m_in = '0;
    e_ack = '0; e_out = '0; e_err = 1'b0; e_mc = 1'b0;
    e_ma = '0; e_marr = '0; e_midx = '0; e_min = '0;
    for (int k = 0; k < N; k++) e_st[k] = 0;
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    e_ack = '0;
    if (m_busy) begin
      m_d++;
      if (m_d == 1) begin
        e_ma = m_act; e_marr = m_arr;
        e_midx = m_idx; e_min = m_in;
        if (act_ok(m_act)) e_mc = ~e_mc;
      end
      if (m_d == 2 + LAT) begin
        e_ack[m_w] = 1'b1;
        if (act_ok(m_act)) begin
          e_out = heap_f(m_arr, m_idx, m_in);
          e_err = (heap_e(m_in) != 0);
        end else begin
          e_out = '0;
          e_err = 1'b1;
        end
        m_busy = 0;
      end
    end else if (req != '0) begin
      for (int j = 0; j < N; j++) begin
        if (req[(m_ptr + j) % N]) begin
          m_w = (m_ptr + j) % N;
          break;
        end
      end
      m_ptr = (m_w + 1) % N;
      m_act = req_action[8*m_w +: 8];
      m_arr = req_array[AB*m_w +: AB];
      m_idx = req_index[IB*m_w +: IB];
      m_in  = req_in[DB*m_w +: DB];
      if (e_st[m_w] < 16'hFFFF) e_st[m_w]++;
      m_busy = 1;
      m_d = 0;
    end
  endtask

  task automatic compare();
    chk("ack", ack, e_ack);
    chk("resp_out", resp_out, e_out);
    if (e_ack != '0) chk("resp_error", resp_error, e_err);
    chk("mem_clock", mem_clock, e_mc);
    chk("mem_action", mem_action, e_ma);
    chk("mem_array", mem_array, e_marr);
    chk("mem_index", mem_index, e_midx);
    chk("mem_in", mem_in, e_min);
`ifdef HEAP_ARBITER_STATS_EN
    for (int k = 0; k < N; k++)
      chk("stats", stats_grants[16*k +: 16], e_st[k]);
`else
    chk("stats", stats_grants, 0);
`endif
  endtask

  task automatic heap_upd();
    if (mem_clock !== last_mc) begin
      last_mc = mem_clock;
      mem_out = heap_f(mem_array, mem_index, mem_in);
      mem_error = heap_e(mem_in);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    model_step();
    compare();
    heap_upd();
  endtask

  task automatic set_req(input int i, input logic [7:0] a,
                         input logic [AB-1:0] ar,
                         input logic [IB-1:0] ix,
                         input logic [DB-1:0] d);
    req[i] = 1'b1;
    req_action[8*i +: 8] = a;
    req_array[AB*i +: AB] = ar;
    req_index[IB*i +: IB] = ix;
    req_in[DB*i +: DB] = d;
  endtask

  task automatic new_op(input int i);
    logic [7:0] a;
    case ($urandom_range(3))
      0, 1: a = 8'd4;
      2: a = 8'd9;
      default: a = 8'($urandom);
    endcase
    set_req(i, a, AB'($urandom), IB'($urandom), DB'($urandom));
  endtask

  task automatic scramble(input int i);
    req_action[8*i +: 8] = 8'($urandom);
    req_in[DB*i +: DB] = DB'($urandom);
  endtask

  logic mc0;
  int   wins [5];
  int   when [5];
  int   nw;

  initial begin
    model_reset();
    tick();
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_resp_out", resp_out, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_mem_clock", mem_clock, 0);
    chk("rst_mem_in", mem_in, 0);
    reset = 1'b1;
    tick();

    // single SIZE request from requester 0
    mc0 = mem_clock;
    set_req(0, 8'd4, 2'd1, 1'd0, 12'd1);
    tick();
    chk("t1_no_early_toggle", mem_clock, mc0);
    tick();
    chk("t1_toggle_e1", mem_clock, !mc0);
    tick();
    chk("t1_no_ack_e2", ack, 0);
    tick();
    chk("t1_ack", ack, 4'b0001);
    chk("t1_out", resp_out, 12'd2);
    chk("t1_err", resp_error, 0);
    chk("t1_one_toggle", mem_clock, !mc0);
    req[0] = 1'b0;
    tick();

    // fresh pointer, all requesting
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'd9, '0, '0, DB'(i));
    nw = 0;
    for (int t = 1; t <= 40 && nw < 5; t++) begin
      tick();
      if (ack != '0) begin
        for (int k = 0; k < N; k++)
          if (ack[k]) wins[nw] = k;
        when[nw] = t;
        nw++;
      end
    end
    req = '0;
    chk("rr_count", nw, 5);
    chk("rr_w0", wins[0], 0);
    chk("rr_w1", wins[1], 1);
    chk("rr_w2", wins[2], 2);
    chk("rr_w3", wins[3], 3);
    chk("rr_w4", wins[4], 0);
    chk("rr_first", when[0], 4);
    for (int k = 1; k < 5; k++)
      chk("rr_gap", when[k] - when[k-1], 4);
    tick();

    // unsupported action
    mc0 = mem_clock;
    set_req(2, 8'd7, 2'd1, 1'd1, 12'd3);
    tick();
    tick();
    chk("t3_no_toggle", mem_clock, mc0);
    tick();
    tick();
    chk("t3_ack", ack, 4'b0100);
    chk("t3_err", resp_error, 1);
    chk("t3_out", resp_out, 0);
    req[2] = 1'b0;
    tick();

    // reset while waiting
    set_req(3, 8'd4, 2'd2, 1'd0, 12'd9);
    tick();
    tick();
    #1 reset = 1'b0;
    #1;
    chk("t4_ack", ack, 0);
    chk("t4_mclk", mem_clock, 0);
    chk("t4_mact", mem_action, 0);
    chk("t4_min", mem_in, 0);
    chk("t4_out", resp_out, 0);
    chk("t4_err", resp_error, 0);
    chk("t4_stats", stats_grants, 0);
    model_reset();
    req = '0;
    tick();
    tick();
    reset = 1'b1;
    set_req(1, 8'd9, 2'd2, 1'd1, 12'd7);
    tick();
    tick();
    tick();
    tick();
    chk("t4_after_ack", ack, 4'b0010);
    chk("t4_after_out", resp_out, 12'd10);
    req[1] = 1'b0;
    tick();

    // requester drops right after its grant
    set_req(1, 8'd4, 2'd2, 1'd1, 12'd5);
    tick();
    req[1] = 1'b0;
    scramble(1);
    tick();
    tick();
    tick();
    chk("t5_ack", ack, 4'b0010);
    chk("t5_err", resp_error, 1);
    chk("t5_out", resp_out, 12'd8);
    tick();

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(1) == 1) new_op(i);
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(3) == 0) new_op(i);
        end else if (m_busy && m_w == i &&
                     $urandom_range(15) == 0) begin
          req[i] = 1'b0;
          scramble(i);
        end
      end
      tick();
    end
    req = '0;
    for (int t = 0; t < 8; t++) tick();

`ifdef HEAP_ARBITER_STATS_EN
    set_req(3, 8'd4, '0, '0, '0);
    for (int g = 0; g < 70000 * 4; g++) tick();
    req = '0;
    tick();
    tick();
    tick();
    tick();
    chk("sat_stats3", stats_grants[48 +: 16], 16'hFFFF);
`else
    chk("nostats_zero", stats_grants, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/heap_arbiter.md
HEAP_ARBITER -- requirements
Module: heap_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 4: number of independent requesters sharing one heap memory.
REQ-002 Parameter ADDRESS_BITS, default 2: width of the array number.
REQ-003 Parameter INDEX_BITS, default 1: width of the index within an array.
REQ-004 Parameter DATA_BITS, default 12: width of heap data.
REQ-005 Parameter LATENCY, default 1: cycles waited after a memory transition before its output is sampled (range 1..15).
REQ-006 clock  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req  input  REQUESTERS  per-requester request; held high until its ack.
REQ-009 req_action  input  8*REQUESTERS  packed per-requester operation code.
REQ-010 req_array  input  ADDRESS_BITS*REQUESTERS  packed array numbers.
REQ-011 req_index  input  INDEX_BITS*REQUESTERS  packed indices.
REQ-012 req_in  input  DATA_BITS*REQUESTERS  packed input data.
REQ-013 ack  output  REQUESTERS  one-hot, one-cycle completion pulse.
REQ-014 resp_out  output  DATA_BITS  result, valid only while any ack bit is high.
REQ-015 resp_error  output  1  error flag, valid only while any ack bit is high.
REQ-016 mem_clock  output  1  heap transition strobe; heap acts on every edge of it.
REQ-017 mem_action, mem_array, mem_index, mem_in  output  8, ADDRESS_BITS, INDEX_BITS, DATA_BITS  registered heap command bus.
REQ-018 mem_out  input  DATA_BITS; mem_error  input  32  heap results.
REQ-019 stats_grants  output  16*REQUESTERS  per-requester grant counters.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP, encoded as a single state register.
REQ-021 IDLE: with any req high, grant the round-robin winner (first requester at or after pointer, wrapping), latch its operands, go to ISSUE; otherwise stay.
REQ-022 Round-robin pointer becomes winner+1 modulo REQUESTERS on every grant.
REQ-023 ISSUE: drive latched operands on mem_* bus and toggle mem_clock on the same edge; go to WAIT.
REQ-024 WAIT: remain exactly LATENCY cycles, then go to RESP.
REQ-025 RESP: register mem_out into resp_out, resp_error = (mem_error != 0), pulse ack[winner] for one cycle, return to IDLE.
REQ-026 Latency: req sampled at edge E0 -> mem_clock toggles at E1 -> ack high from E(2+LATENCY) for one cycle (LATENCY=1: ack after E3).
REQ-027 Supported actions: HEAP_ACTION_SIZE (4) and HEAP_ACTION_GREATER (9); any other code skips the mem_clock toggle, keeps identical latency, acks with resp_error=1 and resp_out=0.
REQ-028 Requester dropping req before ack: operation still completes and ack still pulses.
REQ-029 Requester holding req after ack: treated as a new request, arbitrated normally in the following IDLE cycle.
REQ-030 Simultaneous requests: exactly one grant per operation; no requester starves beyond REQUESTERS-1 other grants.
REQ-031 mem_* bus and resp_out hold their last values between operations.

Reset
REQ-032 reset low asynchronously forces state=IDLE, pointer=0, ack=0, resp_out=0, resp_error=0, mem_clock=0, mem_action/array/index/in=0, stats_grants=0.
REQ-033 Reset mid-operation abandons the operation; no ack is produced for it.

Configuration
REQ-034 Macro HEAP_ARBITER_STATS_EN defined: each stats_grants field increments on its requester's grant, saturating at 16'hFFFF.
REQ-035 Macro undefined: counters not built; stats_grants port present and tied to 0.

Structure
REQ-036 Shared package heap_pkg holds action codes HEAP_ACTION_SIZE/HEAP_ACTION_GREATER and the FSM state typedef.
REQ-037 Sub-module heap_rr_pick: combinational round-robin winner select (req vector, pointer -> one-hot grant, valid).

Verification
REQ-038 Single req[0], action 4, array 1, mem_out=2 -> mem_clock toggles once at E1, ack=0001 after E3, resp_out=2, resp_error=0.
REQ-039 req=1111 held continuously, pointer 0 -> grants in order 0,1,2,3,0; each ack one cycle, 4 cycles apart (LATENCY=1).
REQ-040 req[2] action 7 -> no mem_clock toggle, ack=0100 after E3, resp_error=1, resp_out=0.
REQ-041 reset low during WAIT -> all outputs 0 immediately, no ack; new request after release completes normally.
REQ-042 req[1] dropped one cycle after grant -> ack[1] still pulses after E3; mem_error=5 -> resp_error=1.
REQ-043 STATS_EN build, 70000 grants to requester 3 -> stats_grants[3]=16'hFFFF; non-STATS build -> stats_grants=0.
